// File: rtl/lane_load_scheduler_if.sv
// Source word stream (valid/ready) feeding the lane load scheduler.
interface lane_load_scheduler_if #(
  parameter int unsigned W = 32
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  // Payload source side
  modport master (output valid, output data, input ready);
  // Scheduler side
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/lane_load_scheduler.sv
// Sequences BURST words into each of the 8 alignment FIFOs (lanes 0..7) via the
// data switch, then waits for all-full and all-empty before returning idle.
module lane_load_scheduler #(
  parameter int unsigned W     = 32,
  parameter int unsigned BURST = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  lane_load_scheduler_if.slave        src,
  input  logic [7:0]                  lane_full,
  input  logic [7:0]                  lane_empty,
  output logic [2:0]                  sw_rptr,
  output logic                        sw_select,
  output logic [W-1:0]                sw_data,
  output logic                        busy,
  output logic                        load_done,
  output logic                        drain_done,
  output logic                        overflow_err
);

  localparam int unsigned   CW   = $clog2(BURST) + 1;
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_FULL, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sw_rptr_q, sw_rptr_d;
  logic          pend_q, pend_d;
  logic [W-1:0]  pend_data_q, pend_data_d;
  logic          sw_select_q, sw_select_d;
  logic [W-1:0]  sw_data_q, sw_data_d;
  logic          busy_q, busy_d;
  logic          load_done_q, load_done_d;
  logic          drain_done_q, drain_done_d;
  logic          ovf_q, ovf_d;
  logic          lane_full_c;
  logic          ready_c;
  logic          accept_c;

  // Handshake: words are only taken while loading into a lane with room.
  // Being in LOAD already implies fewer than 8*BURST words have been issued.
  assign lane_full_c = lane_full[ptr_q];
  assign ready_c     = (state_q == LOAD) && !lane_full_c;
  assign accept_c    = ready_c && src.valid;
  assign src.ready   = ready_c;

  // Next-state, lane/burst sequencing and switch pipeline.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    sw_rptr_d    = sw_rptr_q;
    pend_d       = accept_c;
    pend_data_d  = accept_c ? src.data : '0;
    sw_select_d  = pend_q;
    sw_data_d    = pend_data_q;
    load_done_d  = 1'b0;
    drain_done_d = 1'b0;
    ovf_d        = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          ptr_d   = 3'd0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      LOAD: begin
        if (lane_full_c) begin
          // Lane filled before its quota: flag it and drop the rest of the quota.
          ovf_d = 1'b1;
          cnt_d = '0;
          if (ptr_q == 3'd7) state_d = WAIT_FULL;
          else               ptr_d   = ptr_q + 3'd1;
        end else if (src.valid) begin
          sw_rptr_d = ptr_q;
          if (cnt_q == LAST) begin
            cnt_d = '0;
            if (ptr_q == 3'd7) state_d = WAIT_FULL;
            else               ptr_d   = ptr_q + 3'd1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      WAIT_FULL: begin
        if (lane_full == 8'hFF) begin
          load_done_d = 1'b1;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (lane_empty == 8'hFF) begin
          drain_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      ptr_q        <= 3'd0;
      cnt_q        <= '0;
      sw_rptr_q    <= 3'd0;
      pend_q       <= 1'b0;
      pend_data_q  <= '0;
      sw_select_q  <= 1'b0;
      sw_data_q    <= '0;
      busy_q       <= 1'b0;
      load_done_q  <= 1'b0;
      drain_done_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      sw_rptr_q    <= sw_rptr_d;
      pend_q       <= pend_d;
      pend_data_q  <= pend_data_d;
      sw_select_q  <= sw_select_d;
      sw_data_q    <= sw_data_d;
      busy_q       <= busy_d;
      load_done_q  <= load_done_d;
      drain_done_q <= drain_done_d;
      ovf_q        <= ovf_d;
    end
  end

  assign sw_rptr      = sw_rptr_q;
  assign sw_select    = sw_select_q;
  assign sw_data      = sw_data_q;
  assign busy         = busy_q;
  assign load_done    = load_done_q;
  assign drain_done   = drain_done_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_lane_load_scheduler.sv
// Randomized bench for lane_load_scheduler: a lane-quota reference model predicts
// the handshake, switch pointer/data timing and completion pulses.
module tb_lane_load_scheduler;

  localparam int unsigned W     = 32;
  localparam int unsigned BURST = 8;

  logic         clk        = 1'b0;
  logic         resetn     = 1'b0;
  logic         start      = 1'b0;
  logic [7:0]   lane_full  = 8'h00;
  logic [7:0]   lane_empty = 8'hFF;
  logic [2:0]   sw_rptr;
  logic         sw_select;
  logic [W-1:0] sw_data;
  logic         busy, load_done, drain_done, overflow_err;

  int           n_vec = 0;
  int           n_err = 0;
  logic [2:0]   exp_rptr = 3'd0;

  lane_load_scheduler_if #(.W(W)) src_if ();

  always #5 clk = ~clk;

  lane_load_scheduler #(.W(W), .BURST(BURST)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .src          (src_if),
    .lane_full    (lane_full),
    .lane_empty   (lane_empty),
    .sw_rptr      (sw_rptr),
    .sw_select    (sw_select),
    .sw_data      (sw_data),
    .busy         (busy),
    .load_done    (load_done),
    .drain_done   (drain_done),
    .overflow_err (overflow_err)
  );

  // Runs one load: lane quotas are BURST words, except lane 3 which gets 2 when ovf is set.
  task automatic run_load(input int vmode, input bit ovf, input int abort_at, input bit noise);
    int         quota[8];
    int         lane_cnt[8];
    int         lane_q[$];
    int         len;
    int         n;
    int         cyc;
    int         ovf_idx;
    bit         skipped;
    bit         prev_acc;
    bit         ready_exp;
    bit         acc;
    bit         v;
    logic [W-1:0] prev_data;
    logic [W-1:0] d;
    len = 0; n = 0; cyc = 0; skipped = 0; prev_acc = 0; prev_data = '0;
    ovf_idx = 3 * BURST + 2;
    for (int l = 0; l < 8; l++) begin
      quota[l]    = (ovf && l == 3) ? 2 : BURST;
      lane_cnt[l] = 0;
      len        += quota[l];
      for (int k = 0; k < quota[l]; k++) lane_q.push_back(l);
    end
    while (n < len || prev_acc) begin
      if (abort_at >= 0 && n == abort_at) return;
      cyc++;
      if (cyc > 1000) begin
        n_vec++; n_err++;
        $display("FAIL load_timeout words=%0d required=%0d", n, len);
        return;
      end
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 1;
        default: v = 1'($urandom_range(0, 1));
      endcase
      d = W'($urandom);
      src_if.valid = v;
      src_if.data  = d;
      if (ovf && n >= ovf_idx) lane_full[3] = 1'b1;
      start     = noise && ($urandom_range(0, 5) == 0);
      ready_exp = (n < len) && !(ovf && n == ovf_idx && !skipped);
      #1;
      n_vec++;
      if (src_if.ready !== ready_exp) begin
        n_err++;
        $display("FAIL src_ready word=%0d got %b want %b", n, src_if.ready, ready_exp);
      end
      acc = v && ready_exp;
      if (acc) exp_rptr = 3'(lane_q[n]);
      @(posedge clk); #1;
      if (ovf && n == ovf_idx && !skipped) skipped = 1;
      n_vec++;
      if (sw_rptr !== exp_rptr) begin
        n_err++;
        $display("FAIL sw_rptr word=%0d got %0d want %0d", n, sw_rptr, exp_rptr);
      end
      n_vec++;
      if (sw_select !== prev_acc || sw_data !== (prev_acc ? prev_data : '0)) begin
        n_err++;
        $display("FAIL sw_sel_data word=%0d got %b/%h want %b/%h", n, sw_select, sw_data,
                 prev_acc, prev_acc ? prev_data : '0);
      end
      n_vec++;
      if (busy !== 1'b1 || overflow_err !== (ovf && skipped)) begin
        n_err++;
        $display("FAIL busy_ovf word=%0d got %b/%b want 1/%b", n, busy, overflow_err, ovf && skipped);
      end
      if (acc && !$isunknown(sw_rptr)) lane_cnt[sw_rptr]++;
      prev_acc  = acc;
      prev_data = d;
      if (acc) n++;
    end
    src_if.valid = 1'b0;
    start        = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (sw_select !== 1'b0 || sw_data !== '0 || busy !== 1'b1 || load_done !== 1'b0) begin
      n_err++;
      $display("FAIL load_tail got sel=%b data=%h busy=%b ld=%b want 0/0/1/0",
               sw_select, sw_data, busy, load_done);
    end
    for (int l = 0; l < 8; l++) begin
      n_vec++;
      if (lane_cnt[l] !== quota[l]) begin
        n_err++;
        $display("FAIL lane_words lane=%0d got %0d want %0d", l, lane_cnt[l], quota[l]);
      end
    end
  endtask

  // Raises remaining full flags one per cycle, then empties all lanes one per cycle.
  task automatic finish_load(input bit noise);
    int order[$];
    int perm[8];
    int j, t, last;
    for (int l = 0; l < 8; l++) if (!lane_full[l]) order.push_back(l);
    last = order.size() - 1;
    for (int i = 0; i <= last; i++) begin
      lane_full[order[i]] = 1'b1;
      start = noise && ($urandom_range(0, 2) == 0);
      @(posedge clk); #1;
      n_vec++;
      if (load_done !== (i == last) || busy !== 1'b1) begin
        n_err++;
        $display("FAIL load_done step=%0d got %b busy=%b want %b busy=1", i, load_done, busy, i == last);
      end
    end
    for (int l = 0; l < 8; l++) perm[l] = l;
    for (int l = 7; l > 0; l--) begin
      j = $urandom_range(0, l); t = perm[l]; perm[l] = perm[j]; perm[j] = t;
    end
    lane_full  = 8'h00;
    lane_empty = 8'h00;
    for (int i = 0; i < 8; i++) begin
      lane_empty[perm[i]] = 1'b1;
      start = noise && ($urandom_range(0, 2) == 0);
      @(posedge clk); #1;
      n_vec++;
      if (drain_done !== (i == 7) || busy !== (i != 7) || load_done !== 1'b0) begin
        n_err++;
        $display("FAIL drain step=%0d got dd=%b busy=%b ld=%b want %b/%b/0",
                 i, drain_done, busy, load_done, i == 7, i != 7);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (drain_done !== 1'b0 || busy !== 1'b0 || src_if.ready !== 1'b0 || sw_rptr !== exp_rptr) begin
      n_err++;
      $display("FAIL idle_after_drain got dd=%b busy=%b rdy=%b rptr=%0d want 0/0/0/%0d",
               drain_done, busy, src_if.ready, sw_rptr, exp_rptr);
    end
  endtask

  task automatic do_start();
    lane_full    = 8'h00;
    lane_empty   = 8'h00;
    src_if.valid = 1'b0;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || overflow_err !== 1'b0 || load_done !== 1'b0) begin
      n_err++;
      $display("FAIL start got busy=%b ovf=%b ld=%b want 1/0/0", busy, overflow_err, load_done);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; src_if.valid = 1'b0; src_if.data = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, load_done, drain_done, overflow_err, sw_select, src_if.ready, sw_rptr, sw_data} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got busy=%b ld=%b dd=%b ovf=%b sel=%b rdy=%b rptr=%0d data=%h want all 0",
               busy, load_done, drain_done, overflow_err, sw_select, src_if.ready, sw_rptr, sw_data);
    end
    resetn   = 1'b1;
    exp_rptr = 3'd0;
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b0 || src_if.ready !== 1'b0) begin
      n_err++;
      $display("FAIL idle_no_start got busy=%b rdy=%b want 0/0", busy, src_if.ready);
    end
  endtask

  task automatic test_full_rate();
    do_start(); run_load(0, 1'b0, -1, 1'b0); finish_load(1'b0);
  endtask

  task automatic test_throttled();
    do_start(); run_load(1, 1'b0, -1, 1'b1); finish_load(1'b1);
  endtask

  task automatic test_random();
    do_start(); run_load(2, 1'b0, -1, 1'b1); finish_load(1'b1);
  endtask

  task automatic test_overflow();
    do_start(); run_load(2, 1'b1, -1, 1'b0); finish_load(1'b0);
    n_vec++;
    if (overflow_err !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_sticky got %b want 1", overflow_err);
    end
    do_start(); run_load(0, 1'b0, -1, 1'b0); finish_load(1'b0);
  endtask

  task automatic test_reset_midload();
    do_start(); run_load(0, 1'b0, 5 * BURST + 3, 1'b0);
    #1 resetn = 1'b0; start = 1'b0;
    #1;
    n_vec++;
    if ({busy, load_done, drain_done, overflow_err, sw_select, src_if.ready, sw_rptr, sw_data} !== '0) begin
      n_err++;
      $display("FAIL async_reset got busy=%b sel=%b rdy=%b rptr=%0d data=%h want all 0",
               busy, sw_select, src_if.ready, sw_rptr, sw_data);
    end
    @(posedge clk); #1;
    resetn       = 1'b1;
    src_if.valid = 1'b0;
    exp_rptr     = 3'd0;
    do_start(); run_load(0, 1'b0, -1, 1'b0); finish_load(1'b0);
  endtask

  task automatic test_back_to_back();
    do_start(); run_load(2, 1'b0, -1, 1'b1); finish_load(1'b1);
    do_start(); run_load(0, 1'b0, -1, 1'b1); finish_load(1'b0);
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_throttled();
    test_random();
    test_overflow();
    test_reset_midload();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lane_load_scheduler.md
Name: lane_load_scheduler

Overview:
- Sequences payload loading into the 8 alignment FIFOs (West 1-4, North 1-4) through the data switching stage.
- Accepts a valid/ready word stream and drives the switch's lane pointer, select and data so each lane receives exactly BURST words in lane order 0..7.
- Then waits for all lanes full, and tracks the drain (all empty) before returning idle.
- Sits between the payload source (DMA/memory reader) and the switch; one load per start pulse.

Parameters:
- W, 32, payload width.
- BURST, 8, words written per lane per load (= alignment FIFO depth, >=1).

Ports:
- clk  input  1  system clock, rising edge
- resetn  input  1  asynchronous active-low reset
- start  input  1  pulse; begins a load when idle, ignored otherwise
- src_valid  input  1  source word valid
- src_data  input  W  source word
- src_ready  output  1  word accepted on edge where src_valid && src_ready
- lane_full  input  8  FIFO full flags; bits 0-3 = West 1-4, bits 4-7 = North 1-4
- lane_empty  input  8  FIFO empty flags, same bit order
- sw_rptr  output  3  lane pointer to switch (switch registers it internally one cycle)
- sw_select  output  1  switch enable, one cycle per word
- sw_data  output  W  payload to switch
- busy  output  1  high in any state except IDLE
- load_done  output  1  one-cycle pulse when all lanes report full
- drain_done  output  1  one-cycle pulse when all lanes report empty after a load
- overflow_err  output  1  sticky: lane went full before its BURST words were written

Behaviour:
- Reset (async): state IDLE; src_ready, sw_select, busy, load_done, drain_done, overflow_err = 0; sw_rptr = 0; sw_data = 0; lane ptr = 0; burst count = 0. Reset mid-load aborts immediately; no partial state survives.
- All outputs are registered, except src_ready. src_ready is combinational: (state==LOAD) && !lane_full[ptr] && (words issued < 8*BURST).
- FSM states and transitions:
  - IDLE -> LOAD on start; ptr = 0, count = 0.
  - LOAD: each accepted word increments count. When count reaches BURST-1 on an accept, count returns to 0 and ptr increments. Accepting the last word of lane 7 goes to WAIT_FULL.
  - WAIT_FULL: src_ready = 0. When lane_full == 8'hFF: pulse load_done, go to DRAIN.
  - DRAIN: when lane_empty == 8'hFF: pulse drain_done, go to IDLE.
- Alignment with the switch:
  - For a word accepted at edge k, sw_rptr holds that word's lane from edge k.
  - sw_data = word and sw_select = 1 from edge k+1, for exactly one cycle.
  - Hence sw_rptr leads data/select by one cycle, matching the switch's internal rptr pipe stage.
  - sw_select = 0 and sw_data = 0 in cycles with no pending word.
  - sw_rptr holds its last value when idle.
- Back-to-back accepts sustain one word per cycle, including across lane boundaries. sw_rptr changes on the same edge the first word of the new lane is accepted.
- Early-full lane: lane_full[ptr] = 1 in LOAD with count < BURST-1 (or at count 0 for a fresh lane):
  - set overflow_err;
  - drop the lane's remaining quota: ptr advances, count = 0;
  - no words are accepted for that lane;
  - if ptr was 7, go to WAIT_FULL.
- overflow_err clears only on reset or on the next start.
- start while busy: ignored.
- Simultaneous lane_full == FF and lane_empty == FF is impossible by construction; all-full is checked first.
- Counters:
  - count width = clog2(BURST)+1, compares against BURST-1.
  - ptr is 3 bits and never wraps inside a load: the transition after lane 7 is to WAIT_FULL.

Test Plan:
- BURST=8, src_valid held high after start -> 64 accepts on consecutive cycles; sw_rptr steps 0..7 every 8 cycles; sw_select high for 64 cycles, lagging sw_rptr by 1; busy=1.
- Source throttled (src_valid toggling 1,0) -> words in the same lane order; sw_select gaps mirror src gaps; no word lost or duplicated (scoreboard by lane).
- After 64 words, lane_full raised one bit per cycle -> load_done pulses once, exactly on the cycle after lane_full==FF; then lane_empty==FF -> drain_done pulse, busy falls, state IDLE.
- lane_full[3] forced high after 2 words into lane 3 -> overflow_err=1; lane 3 gets 2 words; next word routed with sw_rptr=4; total accepts 58.
- resetn low for one cycle mid-lane 5 -> all outputs 0 asynchronously; a fresh start restarts at sw_rptr=0 with a full 64-word load.
- start pulsed during LOAD and DRAIN -> no effect on ptr, count, or state.
